// File: rtl/sbox_bank.sv
// Bank of NUM_SBOX runtime-editable substitution tables with a 1-deep
// valid/ready lookup stage, entry write/readback and a restore-defaults sequencer.
module sbox_bank #(
  parameter int NUM_SBOX = 8,
  parameter int IN_W     = 6,
  parameter int OUT_W    = 4,
  parameter bit DES_INIT = 1'b1,
  localparam int SEL_W   = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SBOX*IN_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_SBOX*OUT_W-1:0] out_data,
  input  logic                      cfg_wr_en,
  input  logic                      cfg_rd_en,
  input  logic [SEL_W-1:0]          cfg_sbox,
  input  logic [IN_W-1:0]           cfg_addr,
  input  logic [OUT_W-1:0]          cfg_wdata,
  output logic [OUT_W-1:0]          cfg_rdata,
  output logic                      cfg_rvalid,
  input  logic                      restore,
  output logic                      busy
);

  localparam int DEPTH = 2 ** IN_W;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RESTORE = 1'b1;

  // DES S1..S8, rows 0..3 concatenated, column 0 in the most significant nibble.
  localparam logic [255:0] DES_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Box k holds S(8-k); the address splits into row {a[IN_W-1],a[0]} and column a[IN_W-2:1].
  function automatic logic [OUT_W-1:0] default_entry(input int box, input int addr);
    int         n;
    logic [2:0] sidx;
    logic [3:0] nib;
    if (DES_INIT) begin
      n    = ((((addr >> (IN_W - 1)) & 1) << 5) | ((addr & 1) << 4) | ((addr >> 1) & 15)) & 63;
      sidx = 3'(7 - box);
      nib  = 4'(DES_TAB[sidx] >> ((63 - n) * 4));
      return OUT_W'(nib);
    end
    return OUT_W'(addr);
  endfunction

  logic [0:0]                state;
  logic [IN_W-1:0]           idx;
  logic                      sel_ok;
  logic [NUM_SBOX-1:0]       wr_hit;
  logic [NUM_SBOX*OUT_W-1:0] lookup_data;
  logic [OUT_W-1:0]          box_rdata [NUM_SBOX];
  logic                      accept;

  assign busy     = (state == ST_RESTORE);
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sel_ok   = ({1'b0, cfg_sbox} < (SEL_W + 1)'(NUM_SBOX));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_hit = '0;
    for (int k = 0; k < NUM_SBOX; k++)
      wr_hit[k] = cfg_wr_en && !busy && sel_ok && (cfg_sbox == k[SEL_W-1:0]);
  end

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_box
    logic [OUT_W-1:0] tab [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // NOTE: tables are flops, not RAM, so reset can load every default in one step.
        for (int a = 0; a < DEPTH; a++) tab[a[IN_W-1:0]] <= default_entry(k, a);
      end else if (busy) begin
        tab[idx] <= default_entry(k, int'(idx));
      end else if (wr_hit[k]) begin
        tab[cfg_addr] <= cfg_wdata;
      end
    end

    assign lookup_data[k*OUT_W +: OUT_W] = tab[in_data[k*IN_W +: IN_W]];
    assign box_rdata[k]                  = tab[cfg_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (restore) state <= ST_RESTORE;
        end
        default: begin
          idx <= idx + 1'b1;
          if (idx == '1) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Reads sample the table before this edge's write lands, so same-cycle
  // read/write and lookup/write both observe the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      out_valid  <= 1'b0;
      out_data   <= '0;
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= lookup_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      cfg_rvalid <= cfg_rd_en && !busy;
      if (cfg_rd_en && !busy) cfg_rdata <= sel_ok ? box_rdata[cfg_sbox] : '0;
    end
  end

endmodule

// File: tb/tb_sbox_bank.sv
// Self-checking bench for sbox_bank: randomized lookups and config traffic
// against a table-level reference model built from the DES S-box definitions.
module tb_sbox_bank;

  localparam int NB = 8;
  localparam int IW = 6;
  localparam int OW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NB*IW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NB*OW-1:0]  out_data;
  logic              cfg_wr_en;
  logic              cfg_rd_en;
  logic [2:0]        cfg_sbox;
  logic [IW-1:0]     cfg_addr;
  logic [OW-1:0]     cfg_wdata;
  logic [OW-1:0]     cfg_rdata;
  logic              cfg_rvalid;
  logic              restore;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  sbox_bank dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_wr_en (cfg_wr_en),
    .cfg_rd_en (cfg_rd_en),
    .cfg_sbox  (cfg_sbox),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .cfg_rvalid(cfg_rvalid),
    .restore   (restore),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // DES S1..S8, each listed as row 0..3, columns 0..15.
  int des_tab [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  int ref_tab [NB][64];

  function automatic int def_val(int k, int a);
    int row, col;
    row = ((a >> 5) & 1) * 2 + (a & 1);
    col = (a >> 1) & 15;
    return des_tab[7 - k][row * 16 + col];
  endfunction

  function automatic logic [NB*OW-1:0] model_lookup(logic [NB*IW-1:0] d);
    logic [NB*OW-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[k*OW +: OW] = 4'(ref_tab[k][int'(d[k*IW +: IW])]);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++)
      for (int a = 0; a < 64; a++) ref_tab[k][a] = def_val(k, a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cfg_wr_en = 1'b0;
    cfg_rd_en = 1'b0;
    cfg_sbox  = '0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    restore   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet_inputs();
    step();
    step();
    n_total++;
    if ({out_valid, out_data, cfg_rvalid, cfg_rdata, busy} !== '0) begin
      $display("FAIL reset_state: got valid=%0b data=%h rvalid=%0b rdata=%h busy=%0b, want all 0",
               out_valid, out_data, cfg_rvalid, cfg_rdata, busy);
    end else n_pass++;
    rst = 1'b0;
    model_reset();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    else n_pass++;
    in_valid = 1'b1;
    in_data  = '0;
    step();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 32'hEFA72C4D)
      $display("FAIL reset_lookup0: got valid=%0b data=%h want 1/efa72c4d", out_valid, out_data);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_drain: got out_valid=%0b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_cfg_read();
    logic [3:0] old_v, new_v;
    cfg_rd_en = 1'b1;
    cfg_sbox  = 3'd2;
    cfg_addr  = 6'b000010;
    step();
    cfg_rd_en = 1'b0;
    n_total++;
    if (cfg_rvalid !== 1'b1 || cfg_rdata !== 4'd1)
      $display("FAIL cfg_read_box2: got rvalid=%0b rdata=%h want 1/1", cfg_rvalid, cfg_rdata);
    else n_pass++;
    step();
    n_total++;
    if (cfg_rvalid !== 1'b0) $display("FAIL cfg_rvalid_pulse: got %0b want 0", cfg_rvalid);
    else n_pass++;
    // read and write of the same entry in one cycle
    old_v     = 4'(ref_tab[6][10]);
    new_v     = old_v ^ 4'hF;
    cfg_rd_en = 1'b1;
    cfg_wr_en = 1'b1;
    cfg_sbox  = 3'd6;
    cfg_addr  = 6'd10;
    cfg_wdata = new_v;
    step();
    cfg_wr_en = 1'b0;
    ref_tab[6][10] = int'(new_v);
    n_total++;
    if (cfg_rvalid !== 1'b1 || cfg_rdata !== old_v)
      $display("FAIL cfg_rw_same: got rvalid=%0b rdata=%h want 1/%h", cfg_rvalid, cfg_rdata, old_v);
    else n_pass++;
    step();
    cfg_rd_en = 1'b0;
    n_total++;
    if (cfg_rdata !== new_v) $display("FAIL cfg_rw_applied: got %h want %h", cfg_rdata, new_v);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      cfg_rd_en = 1'b1;
      cfg_sbox  = 3'($urandom_range(0, NB - 1));
      cfg_addr  = 6'($urandom_range(0, 63));
      step();
      cfg_rd_en = 1'b0;
      n_total++;
      if (cfg_rvalid !== 1'b1 || cfg_rdata !== 4'(ref_tab[cfg_sbox][cfg_addr]))
        $display("FAIL cfg_read_rand box%0d addr%0d: got %0b/%h want 1/%h", cfg_sbox, cfg_addr,
                 cfg_rvalid, cfg_rdata, 4'(ref_tab[cfg_sbox][cfg_addr]));
      else n_pass++;
    end
    step();
  endtask

  task automatic test_cfg_write();
    logic [NB*IW-1:0] d;
    int k, a;
    cfg_wr_en = 1'b1;
    cfg_sbox  = 3'd2;
    cfg_addr  = '0;
    cfg_wdata = 4'd5;
    in_valid  = 1'b1;
    in_data   = '0;
    step();
    cfg_wr_en = 1'b0;
    ref_tab[2][0] = 5;
    n_total++;
    if (out_data !== 32'hEFA72C4D)
      $display("FAIL write_same_cycle: got %h want efa72c4d", out_data);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++;
    if (out_data !== 32'hEFA7254D) $display("FAIL write_then_lookup: got %h want efa7254d", out_data);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      k         = $urandom_range(0, NB - 1);
      a         = $urandom_range(0, 63);
      cfg_wr_en = 1'b1;
      cfg_sbox  = 3'(k);
      cfg_addr  = 6'(a);
      cfg_wdata = 4'($urandom);
      step();
      cfg_wr_en     = 1'b0;
      ref_tab[k][a] = int'(cfg_wdata);
      d             = 48'({$urandom(), $urandom()});
      d[k*IW +: IW] = 6'(a);
      in_valid      = 1'b1;
      in_data       = d;
      step();
      in_valid = 1'b0;
      n_total++;
      if (out_data !== model_lookup(d))
        $display("FAIL write_rand box%0d addr%0d: got %h want %h", k, a, out_data, model_lookup(d));
      else n_pass++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic             exp_valid, exp_ready;
    logic [NB*OW-1:0] exp_data;
    logic [NB*IW-1:0] d;
    exp_valid = 1'b0;
    exp_data  = '0;
    for (int i = 0; i < 60; i++) begin
      d         = 48'({$urandom(), $urandom()});
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = d;
      #1;
      exp_ready = !exp_valid || out_ready;
      n_total++;
      if (in_ready !== exp_ready) $display("FAIL b2b_in_ready cyc%0d: got %0b want %0b", i, in_ready, exp_ready);
      else n_pass++;
      if (in_valid && exp_ready) begin
        exp_data  = model_lookup(d);
        exp_valid = 1'b1;
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
      step();
      n_total++;
      if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data))
        $display("FAIL b2b_out cyc%0d: got %0b/%h want %0b/%h", i, out_valid, out_data, exp_valid, exp_data);
      else n_pass++;
    end
    quiet_inputs();
    step();
  endtask

  task automatic test_backpressure();
    logic [NB*IW-1:0] d0, d1;
    int               results;
    d0        = 48'({$urandom(), $urandom()});
    d1        = 48'({$urandom(), $urandom()});
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = d0;
    step();
    results = (out_valid === 1'b1) ? 1 : 0;
    in_data = d1;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== model_lookup(d0))
        $display("FAIL stall cyc%0d: got ready=%0b valid=%0b data=%h want 0/1/%h", i, in_ready,
                 out_valid, out_data, model_lookup(d0));
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %0b want 1", in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0;
    if (out_valid === 1'b1) results++;
    n_total++;
    if (out_data !== model_lookup(d1) || results != 2)
      $display("FAIL stall_second: got %h results=%0d want %h results=2", out_data, results, model_lookup(d1));
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL stall_drain: got out_valid=%0b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_restore();
    logic [NB*IW-1:0] hold_d;
    logic [NB*OW-1:0] held;
    int               cnt;
    hold_d    = 48'({$urandom(), $urandom()});
    held      = model_lookup(hold_d);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = hold_d;
    step();
    in_valid = 1'b0;
    restore  = 1'b1;
    step();
    restore = 1'b0;
    cnt     = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL restore_in_ready cyc%0d: got %0b want 0", cnt, in_ready);
      else n_pass++;
      if (cnt == 5) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== held)
          $display("FAIL restore_hold: got %0b/%h want 1/%h", out_valid, out_data, held);
        else n_pass++;
        out_ready = 1'b1;
      end
      if (cnt == 6) begin
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL restore_drain: got out_valid=%0b want 0", out_valid);
        else n_pass++;
      end
      cfg_wr_en = (cnt == 10);
      cfg_sbox  = 3'd0;
      cfg_addr  = '0;
      cfg_wdata = ~4'(def_val(0, 0));
      if (cnt == 13) begin
        n_total++;
        if (cfg_rvalid !== 1'b0) $display("FAIL restore_rd_ignored: got rvalid=%0b want 0", cfg_rvalid);
        else n_pass++;
      end
      cfg_rd_en = (cnt == 12);
      restore   = (cnt == 30);
      step();
    end
    quiet_inputs();
    model_reset();
    n_total++;
    if (cnt != 64) $display("FAIL restore_busy_len: got %0d cycles want 64", cnt);
    else n_pass++;
    for (int a = 0; a < 64; a++) begin
      in_valid = 1'b1;
      in_data  = {NB{6'(a)}};
      step();
      n_total++;
      if (out_data !== model_lookup(in_data))
        $display("FAIL restore_default addr%0d: got %h want %h", a, out_data, model_lookup(in_data));
      else n_pass++;
    end
    in_data = '0;
    step();
    in_valid = 1'b0;
    n_total++;
    if (out_data !== 32'hEFA72C4D) $display("FAIL restore_lookup0: got %h want efa72c4d", out_data);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_restore();
    int cnt;
    cfg_wr_en = 1'b1;
    cfg_sbox  = 3'd5;
    cfg_addr  = 6'd63;
    cfg_wdata = ~4'(def_val(5, 63));
    step();
    cfg_sbox  = 3'd2;
    cfg_addr  = '0;
    cfg_wdata = 4'd5;
    step();
    cfg_wr_en = 1'b0;
    restore   = 1'b1;
    step();
    restore = 1'b0;
    cnt     = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      if (cnt < 20) step();
    end
    n_total++;
    if (cnt != 20) $display("FAIL midrst_reach: got %0d busy cycles want 20", cnt);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL midrst_busy: got busy=%0b valid=%0b want 0/0", busy, out_valid);
    else n_pass++;
    step();
    rst = 1'b0;
    model_reset();
    in_valid = 1'b1;
    in_data  = '0;
    step();
    n_total++;
    if (out_data !== 32'hEFA72C4D) $display("FAIL midrst_lookup0: got %h want efa72c4d", out_data);
    else n_pass++;
    in_data = {NB{6'd63}};
    step();
    in_valid = 1'b0;
    n_total++;
    if (out_data !== model_lookup(in_data))
      $display("FAIL midrst_lookup63: got %h want %h", out_data, model_lookup(in_data));
    else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_cfg_read();
    test_cfg_write();
    test_back_to_back();
    test_backpressure();
    test_restore();
    test_reset_mid_restore();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
